// File: rtl/delay_req_arbiter.sv
// delay_req_arbiter: round-robin sharing of the delay buffer master request port.
// Every requester owns one request slot. Grants rotate through the pending slots. One
// downstream transaction is in flight at a time, and its completion goes back to the
// requester that issued it.
// Optional feature: define DELAY_ARB_TIMEOUT_EN to enable the WAIT watchdog.
module delay_req_arbiter #(
    parameter int unsigned data_width     = 16,
    parameter int unsigned n_req          = 4,
    parameter int unsigned timeout_cycles = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [n_req-1:0]              req_read,
    input  logic [n_req-1:0]              req_write,
    input  logic [n_req*data_width-1:0]   req_handle,
    input  logic [n_req*data_width-1:0]   req_wdata,
    input  logic [n_req*data_width-1:0]   req_winc,
    output logic [data_width-1:0]         req_rdata,
    output logic [n_req-1:0]              req_read_valid,
    output logic [n_req-1:0]              req_write_ack,
    output logic                          delay_read_req,
    output logic                          delay_write_req,
    output logic [data_width-1:0]         delay_req_handle,
    output logic [data_width-1:0]         delay_write_data,
    output logic [data_width-1:0]         delay_write_inc,
    input  logic [data_width-1:0]         delay_read_data,
    input  logic                          delay_read_valid,
    input  logic                          delay_write_ack,
    input  logic                          clear_errors,
    output logic                          busy,
    output logic [$clog2(n_req)-1:0]      grant_idx,
    output logic [n_req-1:0]              overflow,
    output logic                          error
);

    localparam int unsigned idx_w = $clog2(n_req);
    typedef logic [idx_w-1:0] idx_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t state_q, state_d;

    // Per-requester slot storage
    logic [n_req-1:0]      pend_q, slot_rd_q, slot_wr_q;
    logic [data_width-1:0] handle_q [n_req];
    logic [data_width-1:0] wdata_q  [n_req];
    logic [data_width-1:0] winc_q   [n_req];

    // Current transaction
    idx_t                  rr_ptr_q, grant_q, grant_sel;
    logic                  grant_found;
    logic                  cur_rd_q, cur_wr_q, rd_done_q, wr_done_q;
    logic [data_width-1:0] dh_q, dd_q, di_q, rdata_q;
    logic [n_req-1:0]      rv_q, wa_q, ovf_q;
    logic                  stray_q;

    logic                  in_wait, rd_ok, wr_ok, all_done, finish, stray_ev;
    logic                  timeout_fire, timeout_flag;
    logic [n_req-1:0]      pulse, comp_vec, ovf_ev;

    assign in_wait  = (state_q == StWait);
    assign rd_ok    = !cur_rd_q || rd_done_q || delay_read_valid;
    assign wr_ok    = !cur_wr_q || wr_done_q || delay_write_ack;
    assign all_done = in_wait && rd_ok && wr_ok;
    assign finish   = all_done || timeout_fire;
    assign stray_ev = (delay_read_valid && !(in_wait && cur_rd_q)) ||
                      (delay_write_ack && !(in_wait && cur_wr_q));
    assign pulse    = req_read | req_write;
    assign comp_vec = finish ? (n_req'(1) << grant_q) : '0;
    // A pulse into a slot that completes this cycle is accepted, not an overflow
    assign ovf_ev   = pulse & pend_q & ~comp_vec;

`ifdef DELAY_ARB_TIMEOUT_EN
    localparam int unsigned cnt_w = $clog2(timeout_cycles + 1);
    logic [cnt_w-1:0] cnt_q;
    logic             timeout_q;

    assign timeout_fire = in_wait && !all_done && (cnt_q == cnt_w'(timeout_cycles - 1));
    assign timeout_flag = timeout_q;

    // Watchdog: zero while issuing, counts every WAIT cycle; sticky flag on expiry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (in_wait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            timeout_q <= (clear_errors ? 1'b0 : timeout_q) | timeout_fire;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Round-robin search: first pending slot after rr_ptr
    always_comb begin
        int unsigned k;
        idx_t        cand;
        grant_found = 1'b0;
        grant_sel   = rr_ptr_q;
        k           = 0;
        cand        = '0;
        for (int unsigned j = 1; j <= n_req; j++) begin
            k    = (32'(rr_ptr_q) + j) % n_req;
            cand = idx_t'(k);
            if (!grant_found && pend_q[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_found) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot capture and release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= '0;
            slot_rd_q <= '0;
            slot_wr_q <= '0;
            for (int i = 0; i < n_req; i++) begin
                handle_q[i] <= '0;
                wdata_q[i]  <= '0;
                winc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < n_req; i++) begin
                if (pulse[i] && (!pend_q[i] || comp_vec[i])) begin
                    pend_q[i]    <= 1'b1;
                    slot_rd_q[i] <= req_read[i];
                    slot_wr_q[i] <= req_write[i];
                    handle_q[i]  <= req_handle[i*data_width +: data_width];
                    wdata_q[i]   <= req_wdata[i*data_width +: data_width];
                    winc_q[i]    <= req_winc[i*data_width +: data_width];
                end else if (comp_vec[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Grant latch, downstream payload and completion tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q  <= idx_t'(n_req - 1);
            grant_q   <= '0;
            cur_rd_q  <= 1'b0;
            cur_wr_q  <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            dh_q      <= '0;
            dd_q      <= '0;
            di_q      <= '0;
        end else begin
            if (state_q == StIdle && grant_found) begin
                grant_q  <= grant_sel;
                cur_rd_q <= slot_rd_q[grant_sel];
                cur_wr_q <= slot_wr_q[grant_sel];
                dh_q     <= handle_q[grant_sel];
                dd_q     <= wdata_q[grant_sel];
                di_q     <= winc_q[grant_sel];
            end
            if (state_q == StIssue) begin
                rd_done_q <= 1'b0;
                wr_done_q <= 1'b0;
            end else if (in_wait) begin
                if (delay_read_valid && cur_rd_q) rd_done_q <= 1'b1;
                if (delay_write_ack && cur_wr_q) wr_done_q <= 1'b1;
            end
            if (finish) begin
                rr_ptr_q <= grant_q;
            end
        end
    end

    // Requester-side outputs: read data, completion pulses, sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rv_q    <= '0;
            wa_q    <= '0;
            ovf_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            if (in_wait && cur_rd_q && delay_read_valid) begin
                rdata_q <= delay_read_data;
            end else if (timeout_fire && cur_rd_q && !rd_done_q) begin
                rdata_q <= '0;
            end
            rv_q    <= (finish && cur_rd_q) ? comp_vec : '0;
            wa_q    <= (finish && cur_wr_q) ? comp_vec : '0;
            ovf_q   <= (clear_errors ? '0 : ovf_q) | ovf_ev;
            stray_q <= (clear_errors ? 1'b0 : stray_q) | stray_ev;
        end
    end

    assign req_rdata        = rdata_q;
    assign req_read_valid   = rv_q;
    assign req_write_ack    = wa_q;
    assign delay_read_req   = (state_q == StIssue) && cur_rd_q;
    assign delay_write_req  = (state_q == StIssue) && cur_wr_q;
    assign delay_req_handle = dh_q;
    assign delay_write_data = dd_q;
    assign delay_write_inc  = di_q;
    assign busy             = (state_q != StIdle) || (|pend_q);
    assign grant_idx        = grant_q;
    assign overflow         = ovf_q;
    assign error            = (|ovf_q) || stray_q || timeout_flag;

endmodule

// File: tb/tb_delay_req_arbiter.sv
// Self-checking bench for delay_req_arbiter. The bench acts as requesters and as the
// downstream delay master. A transaction-level model predicts every output each cycle.
module tb_delay_req_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_read, req_write;
    logic [N*W-1:0]   req_handle, req_wdata, req_winc;
    logic [W-1:0]     req_rdata;
    logic [N-1:0]     req_read_valid, req_write_ack;
    logic             delay_read_req, delay_write_req;
    logic [W-1:0]     delay_req_handle, delay_write_data, delay_write_inc;
    logic [W-1:0]     delay_read_data;
    logic             delay_read_valid, delay_write_ack;
    logic             clear_errors;
    logic             busy;
    logic [1:0]       grant_idx;
    logic [N-1:0]     overflow;
    logic             error;

    always #5 clk = ~clk;

    delay_req_arbiter #(
        .data_width     (W),
        .n_req          (N),
        .timeout_cycles (TMO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_handle       (req_handle),
        .req_wdata        (req_wdata),
        .req_winc         (req_winc),
        .req_rdata        (req_rdata),
        .req_read_valid   (req_read_valid),
        .req_write_ack    (req_write_ack),
        .delay_read_req   (delay_read_req),
        .delay_write_req  (delay_write_req),
        .delay_req_handle (delay_req_handle),
        .delay_write_data (delay_write_data),
        .delay_write_inc  (delay_write_inc),
        .delay_read_data  (delay_read_data),
        .delay_read_valid (delay_read_valid),
        .delay_write_ack  (delay_write_ack),
        .clear_errors     (clear_errors),
        .busy             (busy),
        .grant_idx        (grant_idx),
        .overflow         (overflow),
        .error            (error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: slot contents plus the one transaction in service
    logic         m_pend [N];
    logic         m_rd   [N];
    logic         m_wr   [N];
    logic [W-1:0] m_h    [N];
    logic [W-1:0] m_d    [N];
    logic [W-1:0] m_i    [N];
    int           m_rr;
    logic         act;        // a transaction is granted and not yet completed
    int           g, iss, rsp_r, rsp_w, done_c;
    logic         c_rd, c_wr, timed;
    int           f_lr = 0, f_lw = 0;   // forced latencies; 0 = random, -1 = no response

    logic [W-1:0] e_rdata, e_dh, e_dd, e_di;
    logic [N-1:0] e_rv, e_wa, e_ovf;
    logic [1:0]   e_grant;
    logic         e_stray, e_tmo;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_rd[i] = 1'b0; m_wr[i] = 1'b0;
            m_h[i] = '0; m_d[i] = '0; m_i[i] = '0;
        end
        m_rr = N - 1; act = 1'b0; g = 0; iss = -10; rsp_r = -1; rsp_w = -1; done_c = -10;
        c_rd = 1'b0; c_wr = 1'b0; timed = 1'b0;
        e_rdata = '0; e_dh = '0; e_dd = '0; e_di = '0;
        e_rv = '0; e_wa = '0; e_ovf = '0; e_grant = '0; e_stray = 1'b0; e_tmo = 1'b0;
    endtask

    task automatic check_outputs();
        logic any_pend;
        any_pend = 1'b0;
        for (int i = 0; i < N; i++) any_pend |= m_pend[i];
        check_eq("req_rdata", req_rdata, e_rdata);
        check_eq("req_read_valid", req_read_valid, e_rv);
        check_eq("req_write_ack", req_write_ack, e_wa);
        check_eq("delay_read_req", delay_read_req, act && cyc == iss && c_rd);
        check_eq("delay_write_req", delay_write_req, act && cyc == iss && c_wr);
        check_eq("delay_req_handle", delay_req_handle, e_dh);
        check_eq("delay_write_data", delay_write_data, e_dd);
        check_eq("delay_write_inc", delay_write_inc, e_di);
        check_eq("busy", busy, (act && cyc >= iss) || any_pend);
        check_eq("grant_idx", grant_idx, e_grant);
        check_eq("overflow", overflow, e_ovf);
        check_eq("error", error, (|e_ovf) || e_stray || e_tmo);
    endtask

    function automatic int pick_lat(input int f);
        if (f != 0) return f;
`ifdef DELAY_ARB_TIMEOUT_EN
        if ($urandom_range(0, 15) == 0) return -1;
`endif
        return int'($urandom_range(1, 6));
    endfunction

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic step(input logic [N-1:0] rd, input logic [N-1:0] wr,
                        input logic clr, input logic swa);
        logic [N*W-1:0] hv, dv, iv;
        logic [W-1:0]   rdin;
        logic [N-1:0]   comp, ovf_ev, new_rv, new_wa;
        logic           drv_rv, drv_wa, stray_ev, comp_now, grant_now, found;
        int             lr, lw;
        check_outputs();
        for (int i = 0; i < N; i++) begin
            hv[i*W +: W] = W'($urandom);
            dv[i*W +: W] = W'($urandom);
            iv[i*W +: W] = W'($urandom);
        end
        rdin     = W'($urandom);
        drv_rv   = act && c_rd && (rsp_r == cyc);
        drv_wa   = (act && c_wr && (rsp_w == cyc)) || swa;
        stray_ev = (drv_rv && !(act && cyc > iss && c_rd)) ||
                   (drv_wa && !(act && cyc > iss && c_wr));
        comp_now = act && (cyc == done_c);
        grant_now = 1'b0;
        if (!act) for (int i = 0; i < N; i++) grant_now |= m_pend[i];
        comp = '0; new_rv = '0; new_wa = '0; ovf_ev = '0;

        if (drv_rv && act && c_rd && cyc > iss) e_rdata = rdin;
        if (comp_now) begin
            comp[g]   = 1'b1;
            new_rv[g] = c_rd;
            new_wa[g] = c_wr;
            if (timed && c_rd && rsp_r < 0) e_rdata = '0;
            m_rr = g;
            act  = 1'b0;
        end
        if (grant_now) begin
            found = 1'b0;
            for (int j = 1; j <= N; j++) begin
                int k;
                k = (m_rr + j) % N;
                if (!found && m_pend[k]) begin
                    found = 1'b1;
                    g = k;
                end
            end
            c_rd = m_rd[g]; c_wr = m_wr[g];
            e_dh = m_h[g]; e_dd = m_d[g]; e_di = m_i[g];
            e_grant = 2'(g);
            iss = cyc + 1;
            lr = pick_lat(f_lr);
            lw = pick_lat(f_lw);
            rsp_r = (c_rd && lr > 0) ? iss + lr : -1;
            rsp_w = (c_wr && lw > 0) ? iss + lw : -1;
            timed = (c_rd && lr < 0) || (c_wr && lw < 0);
            done_c = timed ? iss + TMO : ((rsp_r > rsp_w) ? rsp_r : rsp_w);
            act = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (rd[i] || wr[i]) begin
                if (!m_pend[i] || comp[i]) begin
                    m_pend[i] = 1'b1; m_rd[i] = rd[i]; m_wr[i] = wr[i];
                    m_h[i] = hv[i*W +: W]; m_d[i] = dv[i*W +: W]; m_i[i] = iv[i*W +: W];
                end else begin
                    ovf_ev[i] = 1'b1;
                end
            end else if (comp[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        e_ovf   = (clr ? '0 : e_ovf) | ovf_ev;
        e_stray = (clr ? 1'b0 : e_stray) | stray_ev;
        e_tmo   = (clr ? 1'b0 : e_tmo) | (comp_now && timed);
        e_rv    = new_rv;
        e_wa    = new_wa;

        req_read = rd; req_write = wr;
        req_handle = hv; req_wdata = dv; req_winc = iv;
        clear_errors = clr;
        delay_read_valid = drv_rv; delay_read_data = rdin; delay_write_ack = drv_wa;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic zero_inputs();
        req_read = '0; req_write = '0; req_handle = '0; req_wdata = '0; req_winc = '0;
        clear_errors = 1'b0; delay_read_valid = 1'b0; delay_write_ack = 1'b0;
        delay_read_data = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        zero_inputs();
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
    endtask

    initial begin
        zero_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;

        // Single read from requester 0, downstream data four cycles after the strobe
        f_lr = 4;
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        idle(10);
        f_lr = 0;

        // Fairness from reset pointer, then from pointer 1
        f_lw = 1;
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        idle(20);
        step(4'b0000, 4'b0010, 1'b0, 1'b0);
        idle(8);
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        idle(20);

        // Combined read+write on requester 2
        f_lw = 1; f_lr = 5;
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        idle(12);

        // Overflow on requester 1 while requester 0 holds the port, then clear
        f_lw = 6; f_lr = 0;
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        step(4'b0000, 4'b0010, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0010, 1'b0, 1'b0);
        idle(24);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        idle(2);

        // Reset during WAIT, then a late write ack is stray
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        idle(3);
        apply_reset();
        f_lw = 0;
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        idle(2);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        idle(2);

`ifdef DELAY_ARB_TIMEOUT_EN
        // Read that never completes downstream
        f_lr = -1;
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        idle(14);
        f_lr = 0;
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rd, wr;
            logic         clr, swa;
            for (int i = 0; i < N; i++) begin
                rd[i] = ($urandom_range(0, 7) == 0);
                wr[i] = ($urandom_range(0, 7) == 0);
            end
            clr = ($urandom_range(0, 31) == 0);
            swa = ($urandom_range(0, 23) == 0) && !(act && cyc > iss && c_wr);
            step(rd, wr, clr, swa);
            if (c == 1500) apply_reset();
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
